// File: rtl/core_inst_sequencer_pkg.sv
// Shared definitions for the core instruction sequencer: FSM states, the bit
// positions of the 34-bit core instruction word, and its idle value.
package core_inst_sequencer_pkg;

    localparam int unsigned INST_W = 34;

    // Core instruction word bit map, MSB first.
    localparam int unsigned INST_ACC       = 33;
    localparam int unsigned INST_CEN_P     = 32;
    localparam int unsigned INST_WEN_P     = 31;
    localparam int unsigned INST_AP_MSB    = 30;
    localparam int unsigned INST_AP_LSB    = 20;
    localparam int unsigned INST_CEN_X     = 19;
    localparam int unsigned INST_WEN_X     = 18;
    localparam int unsigned INST_AX_MSB    = 17;
    localparam int unsigned INST_AX_LSB    = 7;
    localparam int unsigned INST_OFIFO_RD  = 6;
    localparam int unsigned INST_IFIFO_WR  = 5;
    localparam int unsigned INST_IFIFO_RD  = 4;
    localparam int unsigned INST_L0_RD     = 3;
    localparam int unsigned INST_L0_WR     = 2;
    localparam int unsigned INST_EXEC      = 1;
    localparam int unsigned INST_LOAD      = 0;

    // Both memories deselected and write-disabled, every strobe low.
    localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

    typedef enum logic [3:0] {
        StIdle,
        StWL0,
        StWLoad,
        StWGap,
        StAL0,
        StExec,
        StDrain,
        StOfRd,
        StAcc,
        StFinish
    } seq_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/core_inst_sequencer_addr_gen.sv
// Accumulation-pass psum address: output pixel o and kernel offset j map to the
// pmem slot holding that pixel's partial sum for kij j. Divisors are
// elaboration-time constants, so power-of-two sizes reduce to shifts/masks.
module seq_addr_gen
    import core_inst_sequencer_pkg::*;
#(
    parameter int unsigned NIJ   = 36,
    parameter int unsigned A_PAD = 6,
    parameter int unsigned O_DIM = 4,
    parameter int unsigned K_DIM = 3,
    parameter int unsigned AW    = 11,
    parameter int unsigned OW    = 4,
    parameter int unsigned JW    = 4
) (
    input  logic [OW-1:0] i_o,
    input  logic [JW-1:0] i_j,
    output logic [AW-1:0] o_addr
);

    logic [31:0] w_o;
    logic [31:0] w_j;
    logic [31:0] w_pix;
    logic [31:0] w_kofs;

    assign w_o    = 32'(i_o);
    assign w_j    = 32'(i_j);
    // Top-left padded pixel of the output window, then kernel shift plus kij bank.
    assign w_pix  = (w_o / O_DIM) * A_PAD + (w_o % O_DIM);
    assign w_kofs = (w_j / K_DIM) * A_PAD + (w_j % K_DIM) + w_j * NIJ;
    assign o_addr = AW'(w_pix + w_kofs);

endmodule

// File: rtl/core_inst_sequencer.sv
// Core instruction sequencer: walks every kernel offset through weight load,
// activation fill, execute, drain and OFIFO write-back, then optionally runs the
// psum accumulation pass. The instruction word is registered.
module core_inst_sequencer
    import core_inst_sequencer_pkg::*;
#(
    parameter int unsigned ROW    = 8,
    parameter int unsigned COL    = 8,
    parameter int unsigned NIJ    = 36,
    parameter int unsigned A_PAD  = 6,
    parameter int unsigned O_DIM  = 4,
    parameter int unsigned K_DIM  = 3,
    parameter int unsigned W_BASE = 'h400,
    parameter int unsigned AW     = 11,
    parameter int unsigned GAP    = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              acc_en,
    input  logic              l0_full,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done,
    output logic [3:0]        kij_idx,
    output logic              acc_valid
);

    localparam int unsigned KIJ  = K_DIM * K_DIM;
    localparam int unsigned ONIJ = O_DIM * O_DIM;
    localparam int unsigned TMAX = max_u(max_u(NIJ, ROW + COL), max_u(GAP, COL));
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned OW   = (ONIJ > 1) ? $clog2(ONIJ) : 1;
    localparam int unsigned JW   = $clog2(KIJ + 1);

    seq_state_e        r_state;
    seq_state_e        w_state_d;
    logic [TW-1:0]     r_t;
    logic [TW-1:0]     w_t_d;
    logic [TW-1:0]     w_t_inc;
    logic [3:0]        r_kij;
    logic [3:0]        w_kij_d;
    logic [3:0]        w_kij_inc;
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     w_wptr_d;
    logic [OW-1:0]     r_o;
    logic [OW-1:0]     w_o_d;
    logic [JW-1:0]     r_j;
    logic [JW-1:0]     w_j_d;
    logic [INST_W-1:0] r_inst;
    logic [INST_W-1:0] w_inst;
    logic              r_busy;
    logic              r_done;
    logic              r_trail;
    logic              w_trail;
    logic              r_acc_valid;
    logic [AW-1:0]     w_w_addr;
    logic [AW-1:0]     w_acc_addr;

    assign w_t_inc   = r_t + TW'(1);
    assign w_kij_inc = r_kij + 4'd1;
    assign w_w_addr  = AW'(W_BASE) + AW'(r_kij) * AW'(COL) + AW'(r_t);

    seq_addr_gen #(
        .NIJ   (NIJ),
        .A_PAD (A_PAD),
        .O_DIM (O_DIM),
        .K_DIM (K_DIM),
        .AW    (AW),
        .OW    (OW),
        .JW    (JW)
    ) u_addr_gen (
        .i_o    (r_o),
        .i_j    (r_j),
        .o_addr (w_acc_addr)
    );

    // Next state, counters and the instruction word for the current phase.
    always_comb begin
        w_state_d = r_state;
        w_t_d     = r_t;
        w_kij_d   = r_kij;
        w_wptr_d  = r_wptr;
        w_o_d     = r_o;
        w_j_d     = r_j;
        w_trail   = 1'b0;
        w_inst    = INST_IDLE;
        // The input FIFO path is not used by this sequencer.
        w_inst[INST_IFIFO_WR] = 1'b0;
        w_inst[INST_IFIFO_RD] = 1'b0;

        case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_d = StWL0;
                    w_t_d     = '0;
                    w_kij_d   = '0;
                    w_wptr_d  = '0;
                    w_o_d     = '0;
                    w_j_d     = '0;
                end
            end
            StWL0: begin
                // A full L0 stalls the fetch: no read, no write, t held.
                if (!l0_full) begin
                    w_inst[INST_CEN_X]                = 1'b0;
                    w_inst[INST_AX_MSB:INST_AX_LSB]   = w_w_addr;
                    w_inst[INST_L0_WR]                = 1'b1;
                    if (r_t == TW'(COL - 1)) begin
                        w_t_d     = '0;
                        w_state_d = StWLoad;
                    end else begin
                        w_t_d = w_t_inc;
                    end
                end
            end
            StWLoad: begin
                w_inst[INST_L0_RD] = 1'b1;
                w_inst[INST_LOAD]  = 1'b1;
                if (r_t == TW'(COL - 1)) begin
                    w_t_d     = '0;
                    w_state_d = StWGap;
                end else begin
                    w_t_d = w_t_inc;
                end
            end
            StWGap: begin
                if (r_t == TW'(GAP - 1)) begin
                    w_t_d     = '0;
                    w_state_d = StAL0;
                end else begin
                    w_t_d = w_t_inc;
                end
            end
            StAL0: begin
                if (!l0_full) begin
                    w_inst[INST_CEN_X]              = 1'b0;
                    w_inst[INST_AX_MSB:INST_AX_LSB] = AW'(r_t);
                    w_inst[INST_L0_WR]              = 1'b1;
                    if (r_t == TW'(NIJ - 1)) begin
                        w_t_d     = '0;
                        w_state_d = StExec;
                    end else begin
                        w_t_d = w_t_inc;
                    end
                end
            end
            StExec: begin
                w_inst[INST_L0_RD] = 1'b1;
                w_inst[INST_EXEC]  = 1'b1;
                if (r_t == TW'(NIJ - 1)) begin
                    w_t_d     = '0;
                    w_state_d = StDrain;
                end else begin
                    w_t_d = w_t_inc;
                end
            end
            StDrain: begin
                w_inst[INST_L0_RD] = 1'b1;
                if (r_t == TW'(ROW + COL - 1)) begin
                    w_t_d     = '0;
                    w_state_d = StOfRd;
                end else begin
                    w_t_d = w_t_inc;
                end
            end
            StOfRd: begin
                // Only pop/write when a complete row is present; otherwise hold.
                if (ofifo_valid) begin
                    w_inst[INST_OFIFO_RD]           = 1'b1;
                    w_inst[INST_CEN_P]              = 1'b0;
                    w_inst[INST_WEN_P]              = 1'b0;
                    w_inst[INST_AP_MSB:INST_AP_LSB] = r_wptr;
                    w_wptr_d                        = r_wptr + AW'(1);
                    if (r_t == TW'(NIJ - 1)) begin
                        w_t_d   = '0;
                        w_kij_d = w_kij_inc;
                        if (32'(w_kij_inc) < KIJ) begin
                            w_state_d = StWL0;
                        end else if (acc_en) begin
                            w_state_d = StAcc;
                        end else begin
                            w_state_d = StFinish;
                        end
                    end else begin
                        w_t_d = w_t_inc;
                    end
                end
            end
            StAcc: begin
                if (r_j != JW'(KIJ)) begin
                    w_inst[INST_CEN_P]              = 1'b0;
                    w_inst[INST_AP_MSB:INST_AP_LSB] = w_acc_addr;
                    w_inst[INST_ACC]                = (r_j != '0);
                    w_j_d                           = r_j + JW'(1);
                end else begin
                    // Trailing cycle lets the SFU add the last read.
                    w_inst[INST_ACC] = 1'b1;
                    w_trail          = 1'b1;
                    w_j_d            = '0;
                    if (r_o == OW'(ONIJ - 1)) begin
                        w_o_d     = '0;
                        w_state_d = StFinish;
                    end else begin
                        w_o_d = r_o + OW'(1);
                    end
                end
            end
            StFinish: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State, counters and registered outputs; reset aborts any run in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_t         <= '0;
            r_kij       <= '0;
            r_wptr      <= '0;
            r_o         <= '0;
            r_j         <= '0;
            r_inst      <= INST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_trail     <= 1'b0;
            r_acc_valid <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_t         <= w_t_d;
            r_kij       <= w_kij_d;
            r_wptr      <= w_wptr_d;
            r_o         <= w_o_d;
            r_j         <= w_j_d;
            r_inst      <= w_inst;
            r_busy      <= (w_state_d != StIdle);
            r_done      <= (r_state == StFinish);
            r_trail     <= w_trail;
            r_acc_valid <= r_trail;
        end
    end

    assign inst      = r_inst;
    assign busy      = r_busy;
    assign done      = r_done;
    assign kij_idx   = r_kij;
    assign acc_valid = r_acc_valid;

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Scoreboard bench for core_inst_sequencer: expected instruction streams are
// queued up front, a negedge monitor pops and compares whenever the DUT shows
// an xmem read, an L0/array strobe, a pmem access, acc_valid or done.
module tb_core_inst_sequencer;
    import core_inst_sequencer_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic              acc_en;
    logic              l0_full;
    logic              ofifo_valid;
    logic [INST_W-1:0] inst;
    logic              busy;
    logic              done;
    logic [3:0]        kij_idx;
    logic              acc_valid;

    core_inst_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .acc_en      (acc_en),
        .l0_full     (l0_full),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done),
        .kij_idx     (kij_idx),
        .acc_valid   (acc_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] addr;
        logic [3:0]  kij;
    } x_exp_t;

    typedef struct packed {
        logic        cen;
        logic        wen;
        logic        acc;
        logic        ofrd;
        logic [10:0] addr;
    } p_exp_t;

    localparam int EV_AV   = 1;
    localparam int EV_DONE = 2;

    x_exp_t     q_x[$];
    logic [2:0] q_c[$];
    p_exp_t     q_p[$];
    int         q_e[$];
    int         q_len[$];

    int n_total = 0;
    int n_bad   = 0;
    bit sb_en   = 1'b0;
    int cyc     = 0;
    int al0_start = 0;
    logic [2:0] prev_code = 3'b000;

    // Hand-computed accumulation addresses for output pixel 5, j = 0..8.
    int acc_o5 [9] = '{7, 44, 81, 121, 158, 195, 235, 272, 309};

    function automatic void chk(input string name, input longint unsigned act,
                                input longint unsigned req);
        n_total++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endfunction

    function automatic void miss(input string name, input string act, input string req);
        n_total++;
        n_bad++;
        $display("FAIL %s actual=%s required=%s", name, act, req);
    endfunction

    task automatic push_run(input bit with_acc, input int stall_kij, input int stall_len);
        x_exp_t xe;
        p_exp_t pe;
        for (int k = 0; k < 9; k++) begin
            for (int t = 0; t < 8; t++) begin
                xe.addr = 11'('h400 + k * 8 + t);
                xe.kij  = 4'(k);
                q_x.push_back(xe);
            end
            for (int t = 0; t < 8; t++) q_c.push_back(3'b101);
            for (int t = 0; t < 36; t++) begin
                xe.addr = 11'(t);
                xe.kij  = 4'(k);
                q_x.push_back(xe);
            end
            for (int t = 0; t < 36; t++) q_c.push_back(3'b011);
            for (int t = 0; t < 16; t++) q_c.push_back(3'b001);
            for (int t = 0; t < 36; t++) begin
                pe = '{cen: 1'b0, wen: 1'b0, acc: 1'b0, ofrd: 1'b1, addr: 11'(k * 36 + t)};
                q_p.push_back(pe);
            end
            q_len.push_back((k == stall_kij) ? 36 + stall_len : 36);
        end
        if (with_acc) begin
            for (int o = 0; o < 16; o++) begin
                for (int j = 0; j < 9; j++) begin
                    int a;
                    if (o == 5) a = acc_o5[j];
                    else a = (o / 4) * 6 + o % 4 + (j / 3) * 6 + j % 3 + j * 36;
                    pe = '{cen: 1'b0, wen: 1'b1, acc: (j != 0), ofrd: 1'b0, addr: 11'(a)};
                    q_p.push_back(pe);
                end
                pe = '{cen: 1'b1, wen: 1'b1, acc: 1'b1, ofrd: 1'b0, addr: 11'(0)};
                q_p.push_back(pe);
                q_e.push_back(EV_AV);
            end
        end
        q_e.push_back(EV_DONE);
    endtask

    // Monitor: samples on the falling edge, away from DUT updates.
    always @(negedge clk) begin : mon
        logic [2:0] code;
        x_exp_t xe;
        p_exp_t pe;
        int     ev;
        int     len;
        cyc++;
        if (sb_en && reset_n) begin
            code = {inst[INST_LOAD], inst[INST_EXEC], inst[INST_L0_RD]};
            if (!inst[INST_CEN_X]) begin
                if (q_x.size() == 0) begin
                    miss("x_extra", $sformatf("0x%0h", inst[INST_AX_MSB:INST_AX_LSB]), "none");
                end else begin
                    xe = q_x.pop_front();
                    chk("x_addr", inst[INST_AX_MSB:INST_AX_LSB], xe.addr);
                    chk("x_l0_wr", inst[INST_L0_WR], 1);
                    chk("x_wen", inst[INST_WEN_X], 1);
                    chk("x_kij", kij_idx, xe.kij);
                    if (xe.addr == 11'd0) al0_start = cyc;
                end
            end else begin
                chk("x_idle_l0_wr", inst[INST_L0_WR], 0);
            end
            if (code != 3'b000) begin
                if (q_c.size() == 0) miss("ctl_extra", $sformatf("%b", code), "none");
                else chk("ctl_code", code, q_c.pop_front());
                if (code == 3'b011 && prev_code != 3'b011) begin
                    if (q_len.size() == 0) begin
                        miss("al0_len_extra", "exec", "none");
                    end else begin
                        len = q_len.pop_front();
                        chk("al0_len", cyc - al0_start, len);
                    end
                end
            end
            prev_code = code;
            if (!inst[INST_CEN_P] || inst[INST_ACC]) begin
                if (q_p.size() == 0) begin
                    miss("p_extra", $sformatf("0x%0h", inst[INST_AP_MSB:INST_AP_LSB]), "none");
                end else begin
                    pe = q_p.pop_front();
                    chk("p_cen", inst[INST_CEN_P], pe.cen);
                    chk("p_wen", inst[INST_WEN_P], pe.wen);
                    chk("p_acc", inst[INST_ACC], pe.acc);
                    chk("p_ofifo_rd", inst[INST_OFIFO_RD], pe.ofrd);
                    if (!pe.cen) chk("p_addr", inst[INST_AP_MSB:INST_AP_LSB], pe.addr);
                end
            end
            if (acc_valid) begin
                if (q_e.size() == 0) begin
                    miss("acc_valid_extra", "pulse", "none");
                end else begin
                    ev = q_e.pop_front();
                    chk("acc_valid_event", EV_AV, ev);
                end
            end
            if (done) begin
                if (q_e.size() == 0) begin
                    miss("done_extra", "pulse", "none");
                end else begin
                    ev = q_e.pop_front();
                    chk("done_event", EV_DONE, ev);
                end
            end
        end
    end

    task automatic tmo(input string name);
        miss(name, "timeout", "event");
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_xaddr(input int k, input int a, input int budget, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!inst[INST_CEN_X] && inst[INST_AX_MSB:INST_AX_LSB] == 11'(a) &&
                kij_idx == 4'(k)) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) tmo(name);
    endtask

    task automatic wait_pwrite(input int a, input int budget, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!inst[INST_CEN_P] && !inst[INST_WEN_P] &&
                inst[INST_AP_MSB:INST_AP_LSB] == 11'(a)) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) tmo(name);
    endtask

    task automatic wait_exec_kij(input int k, input int budget, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (inst[INST_EXEC] && kij_idx == 4'(k)) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) tmo(name);
    endtask

    task automatic wait_kij(input int k, input int budget, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (kij_idx == 4'(k)) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) tmo(name);
    endtask

    task automatic wait_done(input int budget, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) tmo(name);
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_q_x_left"}, q_x.size(), 0);
        chk({tag, "_q_ctl_left"}, q_c.size(), 0);
        chk({tag, "_q_p_left"}, q_p.size(), 0);
        chk({tag, "_q_ev_left"}, q_e.size(), 0);
        chk({tag, "_q_len_left"}, q_len.size(), 0);
    endtask

    initial begin
        reset_n     = 1'b1;
        start       = 1'b0;
        acc_en      = 1'b1;
        l0_full     = 1'b0;
        ofifo_valid = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_inst", inst, INST_IDLE);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_acc_valid", acc_valid, 0);
        chk("reset_kij", kij_idx, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_inst", inst, INST_IDLE);
            chk("idle_busy", busy, 0);
        end

        // Run 1: full run with accumulation, L0 stall in kij1, OFIFO gap in kij2.
        push_run(1'b1, 1, 5);
        sb_en = 1'b1;
        pulse_start();
        chk("run1_busy", busy, 1);
        wait_xaddr(1, 10, 600, "stall_trigger");
        l0_full = 1'b1;
        repeat (5) @(negedge clk);
        l0_full = 1'b0;
        wait_pwrite(77, 600, "ofifo_trigger");
        ofifo_valid = 1'b0;
        repeat (3) @(negedge clk);
        ofifo_valid = 1'b1;
        wait_done(3000, "run1_done");
        chk("run1_done_busy", busy, 0);
        chk("run1_done_inst", inst, INST_IDLE);
        @(negedge clk);
        chk("run1_done_width", done, 0);
        check_drained("run1");

        // Run 2: abort with reset during execute of kij2.
        sb_en  = 1'b0;
        acc_en = 1'b0;
        pulse_start();
        wait_exec_kij(2, 800, "abort_trigger");
        #2 reset_n = 1'b0;
        #1;
        chk("abort_inst", inst, INST_IDLE);
        chk("abort_busy", busy, 0);
        chk("abort_kij", kij_idx, 0);
        @(negedge clk);
        chk("abort_inst_held", inst, INST_IDLE);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Run 3: fresh start without accumulation; a start while busy is ignored.
        push_run(1'b0, -1, 0);
        sb_en = 1'b1;
        pulse_start();
        chk("fresh_kij", kij_idx, 0);
        chk("fresh_busy", busy, 1);
        wait_kij(4, 1000, "busy_start_trigger");
        pulse_start();
        wait_done(2000, "run3_done");
        chk("run3_done_busy", busy, 0);
        @(negedge clk);
        check_drained("run3");
        sb_en = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
